// File: rtl/threeinput_pkg.sv
// threeinput_pkg: shared types and constants for the three-input sweep checker
package threeinput_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  localparam logic [7:0] DEFAULT_EXPECT_F = 8'h5C;
  localparam int ERR_CNT_W = 4;
endpackage

// File: rtl/threeinput_sweep_checker_settle_timer.sv
// sweep_settle_timer: loadable down-counter flagging when a vector has settled
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [3:0] cnt;
  // Load SETTLE_CYCLES-1 so the final APPLY cycle sees zero and expires
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= 4'(SETTLE_CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - 4'd1;
  assign expired = cnt == '0;
endmodule

// File: rtl/threeinput_sweep_checker.sv
// threeinput_sweep_checker: sweeps x,y,z over 8 vectors and checks F/Fn (THREEINPUT_SWEEP_LOOP_EN adds looping)
module threeinput_sweep_checker
  import threeinput_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter logic [7:0] EXPECT_F = DEFAULT_EXPECT_F
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef THREEINPUT_SWEEP_LOOP_EN
  input  logic loop,
`endif
  output logic x,
  output logic y,
  output logic z,
  input  logic F,
  input  logic Fn,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [NUM_VECTORS-1:0] fail_vec
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [ERR_CNT_W-1:0] err_n;
  logic [NUM_VECTORS-1:0] fv_n;
  logic load, expired, bad, wrap;
  sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .load(load), .en(state == APPLY), .expired(expired)
  );
  // Fn must be the exact complement of F, so Fn==F is a failure whatever F is
  assign bad = (F != EXPECT_F[idx]) || (Fn == F);
`ifdef THREEINPUT_SWEEP_LOOP_EN
  assign wrap = loop;
`else
  assign wrap = 1'b0;
`endif
  // Next-state, vector index and scoreboard updates
  always_comb begin
    state_n = state;
    idx_n = idx;
    err_n = err_count;
    fv_n = fail_vec;
    load = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = APPLY;
        idx_n = '0;
        err_n = '0;
        fv_n = '0;
        load = 1'b1;
      end
      APPLY: if (expired) state_n = CHECK;
      CHECK: begin
        if (bad) begin
          fv_n[idx] = 1'b1;
          err_n = (err_count == '1) ? err_count : err_count + 4'd1;
        end
        load = idx != LAST_IDX || wrap;
        state_n = load ? APPLY : DONE;
        idx_n = load ? idx + 3'd1 : idx;
      end
      default: state_n = IDLE;
    endcase
  end
  // State and scoreboard registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      err_count <= '0;
      fail_vec <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      err_count <= err_n;
      fail_vec <= fv_n;
    end
  assign {x, y, z} = idx;
  assign busy = state == APPLY || state == CHECK;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
endmodule

// File: tb/tb_threeinput_sweep_checker.sv
// tb_threeinput_sweep_checker: directed scoreboard bench for the sweep checker
module tb_threeinput_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, F, Fn;
  logic x, y, z, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;
  int mode = 0;
  int checks = 0, errors = 0;
  localparam logic [7:0] EXP = 8'h5C;
  typedef struct {logic pass; logic [3:0] err; logic [7:0] fv;} res_t;
  res_t sb[$];
  logic [2:0] v;
`ifdef THREEINPUT_SWEEP_LOOP_EN
  logic loop = 1'b0;
`endif

  threeinput_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef THREEINPUT_SWEEP_LOOP_EN
    .loop(loop),
`endif
    .x(x), .y(y), .z(z), .F(F), .Fn(Fn), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Function-unit model: 0 correct, 1 F stuck low, 2 Fn==F at vector 5
  assign v = {x, y, z};
  always_comb begin
    F = (mode == 1) ? 1'b0 : EXP[v];
    Fn = (mode == 2 && v == 3'd5) ? F : ~F;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic p, input logic [3:0] e, input logic [7:0] f);
    res_t r;
    r.pass = p;
    r.err = e;
    r.fv = f;
    sb.push_back(r);
  endtask

  task automatic pop_compare(input string tag);
    res_t r;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, "_pass"}, 32'(pass), 32'(r.pass));
      chk({tag, "_err"}, 32'(err_count), 32'(r.err));
      chk({tag, "_fv"}, 32'(fail_vec), 32'(r.fv));
    end
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    pop_compare(tag);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_xyz", 32'(v), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_fv", 32'(fail_vec), 0);

    push(1'b1, 4'd0, 8'h00);
    kick();
    for (int e = 0; e < 16; e++) begin
      if (e > 0) tick();
      chk("sweep_xyz", 32'(v), 32'(e / 2));
      chk("sweep_busy", 32'(busy), 1);
      chk("sweep_done", 32'(done), 0);
    end
    tick();
    chk("clean_done", 32'(done), 1);
    chk("clean_busy", 32'(busy), 0);
    pop_compare("clean");

    mode = 1;
    push(1'b0, 4'd4, 8'h5C);
    kick();
    wait_done("stuck0", 16);

    mode = 2;
    push(1'b0, 4'd1, 8'h20);
    kick();
    wait_done("fn_eq_f", 16);

    mode = 0;
    kick();
    for (int e = 1; e < 8; e++) tick();
    chk("abort_vec3", 32'(v), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_xyz", 32'(v), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(err_count), 0);
    chk("abort_fv", 32'(fail_vec), 0);
    push(1'b1, 4'd0, 8'h00);
    kick();
    wait_done("after_abort", 16);

    push(1'b1, 4'd0, 8'h00);
    start = 1'b1;
    tick();
    for (int e = 1; e < 16; e++) begin
      start = 1'(e % 2);
      tick();
      chk("ignore_start_busy", 32'(busy), 1);
      chk("ignore_start_done", 32'(done), 0);
    end
    start = 1'b0;
    tick();
    chk("ignore_start_done17", 32'(done), 1);
    pop_compare("ignore_start");
    tick();
    tick();
    chk("done_held", 32'(done), 1);

    mode = 1;
    push(1'b0, 4'd4, 8'h5C);
    kick();
    chk("restart_done", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_xyz", 32'(v), 0);
    chk("restart_err", 32'(err_count), 0);
    wait_done("restart", 16);

`ifdef THREEINPUT_SWEEP_LOOP_EN
    loop = 1'b1;
    push(1'b0, 4'd15, 8'h5C);
    kick();
    for (int e = 1; e <= 66; e++) tick();
    chk("loop_busy", 32'(busy), 1);
    loop = 1'b0;
    wait_done("loop", 14);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
